// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - two-requester round-robin arbiter around one shared FP32 multiplier
//
// Purpose:
//   Two requesters share one combinational single-precision multiplier.
//   The sequencer has three states:
//     IDLE - grant one request
//     CALC - register the product
//     RESP - present the result until the owner takes it
//   The product uses truncation only. Zero, Inf, NaN and denormal inputs get no special handling.
//
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   reqN_valid/reqN_a/reqN_b       operand pair offered by requester N (N = 0, 1)
//   reqN_ready                     operands of requester N accepted this cycle
//   rspN_valid/rspN_result         product presented to requester N
//   rspN_ready                     requester N takes the product
//   busy                           an operation is outstanding
//   op_count                       completed response handshakes, wraps at 16 bits

module fp_mul_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic            req1_ready,
    output logic            rsp0_valid,
    output logic [XLEN-1:0] rsp0_result,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    output logic [XLEN-1:0] rsp1_result,
    input  logic            rsp1_ready,
    output logic            busy,
    output logic [15:0]     op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state_q,    state_d;
    logic            rr_ptr_q,   rr_ptr_d;
    logic            owner_q,    owner_d;
    logic [XLEN-1:0] a_q,        a_d;
    logic [XLEN-1:0] b_q,        b_d;
    logic [XLEN-1:0] result_q,   result_d;
    logic [15:0]     op_count_q, op_count_d;

    logic            grant0;
    logic            grant1;
    logic            owner_rsp_ready;

    // Multiplier datapath, always fed from the latched operands.
    logic [23:0]     man_a;
    logic [23:0]     man_b;
    logic [47:0]     prod;
    logic [9:0]      exp_sum;
    logic [22:0]     man_res;
    logic [31:0]     mul_full;
    logic [XLEN-1:0] mul_out;

    always_comb begin
        man_a    = {1'b1, a_q[22:0]};
        man_b    = {1'b1, b_q[22:0]};
        prod     = {24'b0, man_a} * {24'b0, man_b};
        // The bias is removed in 10 bits. Only the low 8 bits are kept, so over- and underflow wrap.
        exp_sum  = {2'b0, a_q[30:23]} + {2'b0, b_q[30:23]} - 10'd127 + {9'b0, prod[47]};
        man_res  = prod[47] ? prod[46:24] : prod[45:23];
        mul_full = {a_q[31] ^ b_q[31], exp_sum[7:0], man_res};
        mul_out  = XLEN'(mul_full);
    end

    // A lone valid requester always wins.
    // When both are valid, rr_ptr picks the winner.
    assign grant0 = req0_valid && (!req1_valid || !rr_ptr_q);
    assign grant1 = req1_valid && !grant0;

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        op_count_d = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    a_d     = grant0 ? req0_a : req1_a;
                    b_d     = grant0 ? req0_b : req1_b;
                    owner_d = grant1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                result_d = mul_out;
                state_d  = S_RESP;
            end
            S_RESP: begin
                // The non-owner's ready is ignored here.
                if (owner_rsp_ready) begin
                    state_d    = S_IDLE;
                    op_count_d = op_count_q + 16'd1;
                    rr_ptr_d   = ~owner_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= 1'b0;
            owner_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            op_count_q <= op_count_d;
        end
    end

    // Handshake outputs are masked while rst is high.
    // This holds even if the state flop still reads CALC/RESP in the reset cycle.
    assign req0_ready  = !rst && (state_q == S_IDLE) && grant0;
    assign req1_ready  = !rst && (state_q == S_IDLE) && grant1;
    assign rsp0_valid  = !rst && (state_q == S_RESP) && !owner_q;
    assign rsp1_valid  = !rst && (state_q == S_RESP) &&  owner_q;
    assign busy        = !rst && (state_q != S_IDLE);
    assign rsp0_result = result_q;
    assign rsp1_result = result_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb/tb_fp_mul_arbiter.sv - self-checking bench for fp_mul_arbiter

module tb_fp_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    int checks   = 0;
    int failures = 0;

    fp_mul_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_ready(rsp1_ready),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference product: real-number reasoning on the significands, done with integer arithmetic.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        longint     ma, mb, p, m;
        int         e;
        logic [7:0] e8;
        logic [22:0] m23;
        ma = 64'h800000 + longint'(a[22:0]);
        mb = 64'h800000 + longint'(b[22:0]);
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= 64'h8000_0000_0000) begin
            m = (p >> 24) & 64'h7FFFFF;
            e = e + 1;
        end else begin
            m = (p >> 23) & 64'h7FFFFF;
        end
        e8  = e[7:0];
        m23 = m[22:0];
        return {a[31] ^ b[31], e8, m23};
    endfunction

    // Transaction-level model.
    //   m_pend   - an accepted request has not yet been taken
    //   m_shown  - the product became visible one cycle after acceptance
    bit          m_pend  = 0;
    bit          m_shown = 0;
    bit          m_owner = 0;
    bit          m_rr    = 0;
    logic [31:0] m_prod  = '0;
    logic [31:0] m_res   = '0;
    logic [15:0] m_count = '0;
    int          grant_log[$];

    always @(negedge clk) begin
        logic e_r0, e_r1, e_v0, e_v1, e_busy, take;
        e_r0   = !rst && !m_pend && req0_valid && (!req1_valid || m_rr == 0);
        e_r1   = !rst && !m_pend && req1_valid && (!req0_valid || m_rr == 1);
        e_v0   = !rst && m_pend && m_shown && m_owner == 0;
        e_v1   = !rst && m_pend && m_shown && m_owner == 1;
        e_busy = !rst && m_pend;
        chk("mdl_req0_ready", 32'(req0_ready), 32'(e_r0));
        chk("mdl_req1_ready", 32'(req1_ready), 32'(e_r1));
        chk("mdl_rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
        chk("mdl_rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
        chk("mdl_busy", 32'(busy), 32'(e_busy));
        chk("mdl_op_count", 32'(op_count), 32'(m_count));
        chk("mdl_rsp0_result", rsp0_result, m_res);
        chk("mdl_rsp1_result", rsp1_result, m_res);
        // Advance the model to the state after the coming rising edge.
        if (rst) begin
            m_pend = 0; m_shown = 0; m_owner = 0; m_rr = 0; m_res = '0; m_count = '0;
        end else if (!m_pend) begin
            if (e_r0 || e_r1) begin
                m_pend  = 1;
                m_shown = 0;
                m_owner = e_r1;
                m_prod  = e_r1 ? fmul(req1_a, req1_b) : fmul(req0_a, req0_b);
                grant_log.push_back(e_r1 ? 1 : 0);
            end
        end else if (!m_shown) begin
            m_shown = 1;
            m_res   = m_prod;
        end else begin
            take = m_owner ? rsp1_ready : rsp0_ready;
            if (take) begin
                m_pend  = 0;
                m_count = m_count + 16'd1;
                m_rr    = !m_owner;
            end
        end
    end

    function automatic logic sig(input int s);
        case (s)
            0:       return req0_ready;
            1:       return req1_ready;
            2:       return rsp0_valid;
            default: return rsp1_valid;
        endcase
    endfunction

    // Called positioned at a falling edge; returns at the falling edge where the signal is high.
    task automatic wait_until(input int s, input string name);
        int n = 0;
        while (!sig(s) && n < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({"timeout_", name}, 32'(sig(s)), 32'd1);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    logic [15:0] saved_cnt;

    initial begin
        // Model pin: literal products.
        chk("pin_fmul_2x3", fmul(32'h40000000, 32'h40400000), 32'h40C00000);
        chk("pin_fmul_1p5sq", fmul(32'h3FC00000, 32'h3FC00000), 32'h40100000);
        chk("pin_fmul_neg2x3", fmul(32'hC0000000, 32'h40400000), 32'hC0C00000);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);

        // Single request, 2.0 * 3.0, two-cycle latency.
        step(); rst = 0;
        req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40400000; rsp0_ready = 1; rsp1_ready = 1;
        @(negedge clk); chk("t1_req0_ready_c0", 32'(req0_ready), 32'd1);
        step(); req0_valid = 0;
        @(negedge clk); chk("t1_rsp0_valid_c1", 32'(rsp0_valid), 32'd0);
        step();
        @(negedge clk); chk("t1_rsp0_valid_c2", 32'(rsp0_valid), 32'd1);
        chk("t1_result", rsp0_result, 32'h40C00000);
        step();
        @(negedge clk); chk("t1_op_count", 32'(op_count), 32'd1);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // Both valid after reset: requester 0 first, then requester 1.
        step(); rst = 1;
        step(); rst = 0;
        req0_valid = 1; req0_a = 32'h3FC00000; req0_b = 32'h3FC00000;
        req1_valid = 1; req1_a = 32'hC0000000; req1_b = 32'h40400000;
        @(negedge clk); chk("t2_req0_first", 32'(req0_ready), 32'd1);
        chk("t2_req1_not", 32'(req1_ready), 32'd0);
        step(); req0_valid = 0;
        @(negedge clk); wait_until(2, "t2_rsp0");
        chk("t2_rsp0_result", rsp0_result, 32'h40100000);
        chk("t2_rsp1_quiet", 32'(rsp1_valid), 32'd0);
        step();
        @(negedge clk); chk("t2_req1_granted", 32'(req1_ready), 32'd1);
        step(); req1_valid = 0;
        @(negedge clk); wait_until(3, "t2_rsp1");
        chk("t2_rsp1_result", rsp1_result, 32'hC0C00000);
        step();

        // Back-pressure while the other requester waits.
        req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40400000; rsp0_ready = 0;
        @(negedge clk); wait_until(0, "t3_grant0");
        step(); req0_valid = 0; req1_valid = 1; req1_a = 32'h3F800000; req1_b = 32'h40A00000;
        @(negedge clk); wait_until(2, "t3_rsp0");
        saved_cnt = op_count;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("t3_hold_valid", 32'(rsp0_valid), 32'd1);
            chk("t3_hold_result", rsp0_result, 32'h40C00000);
            chk("t3_hold_busy", 32'(busy), 32'd1);
            chk("t3_req1_blocked", 32'(req1_ready), 32'd0);
            chk("t3_count_held", 32'(op_count), 32'(saved_cnt));
        end
        step(); rsp0_ready = 1;
        step();
        @(negedge clk); chk("t3_req1_after", 32'(req1_ready), 32'd1);
        chk("t3_count_inc", 32'(op_count), 32'(saved_cnt + 16'd1));
        step(); req1_valid = 0;
        @(negedge clk); wait_until(3, "t3_rsp1");
        chk("t3_rsp1_result", rsp1_result, 32'h40A00000);
        step();

        // Fairness over six operations, starting from reset.
        rst = 1;
        step(); rst = 0;
        grant_log.delete();
        req0_valid = 1; req0_a = 32'h40400000; req0_b = 32'h40400000;
        req1_valid = 1; req1_a = 32'hBF000000; req1_b = 32'h41000000;
        for (int i = 0; i < 60 && grant_log.size() < 6; i++) step();
        req0_valid = 0; req1_valid = 0;
        chk("t4_grant_count", 32'(grant_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk($sformatf("t4_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
        repeat (6) step();

        // Reset during RESP with the result not taken.
        req0_valid = 1; req0_a = 32'h40000000; req0_b = 32'h40000000; rsp0_ready = 0;
        @(negedge clk); wait_until(0, "t5_grant0");
        step(); req0_valid = 0;
        @(negedge clk); wait_until(2, "t5_rsp0");
        step(); rst = 1; req0_valid = 1;
        @(negedge clk); chk("t5_rst_valid", 32'(rsp0_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(req0_ready), 32'd0);
        step(); rst = 0; req0_valid = 0;
        @(negedge clk); chk("t5_count_zero", 32'(op_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk); chk("t5_no_stale", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        end
        rsp0_ready = 1;

        // op_count wrap.
        step();
        force dut.op_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        step();
        release dut.op_count_q;
        req1_valid = 1; req1_a = 32'h40000000; req1_b = 32'h40400000;
        @(negedge clk); wait_until(1, "t6_grant1");
        step(); req1_valid = 0;
        @(negedge clk); wait_until(3, "t6_rsp1");
        step();
        @(negedge clk); chk("t6_wrap", 32'(op_count), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width (IEEE-754 single layout).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_a, req0_b  input  XLEN each  requester 0 operands.
REQ-006 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same as REQ-004..006 for requester 1.
REQ-008 rsp0_valid  output  1  result available for requester 0.
REQ-009 rsp0_result  output  XLEN  product for requester 0.
REQ-010 rsp0_ready  input  1  requester 0 takes result.
REQ-011 rsp1_valid, rsp1_result, rsp1_ready  same as REQ-008..010 for requester 1.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 op_count  output  16  number of completed response handshakes.

Function
REQ-014 The block SHALL share one combinational FP multiplier between two requesters using a 3-state FSM: IDLE, CALC, RESP.
REQ-015 Multiplier arithmetic SHALL be: sign = A[31]^B[31]; mantissas with hidden 1 (24x24 -> 48 bits); exponent = eA+eB-127; if product bit 47 set, mantissa = bits 46:24 and exponent+1, else mantissa = bits 45:23; truncation, no rounding, no special-case (zero/Inf/NaN/denormal) handling.
REQ-016 IDLE: if any reqN_valid, SHALL assert reqN_ready combinationally for exactly one winner, latch its operands and owner id, and go to CALC; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: single valid requester wins; both valid -> requester indicated by rr_ptr wins.
REQ-018 rr_ptr SHALL update to the non-owner id on each response handshake; unchanged otherwise.
REQ-019 reqN_ready SHALL be 0 in CALC and RESP; no operand is accepted while an operation is outstanding.
REQ-020 CALC: SHALL register the multiplier output from latched operands into the result register and go to RESP after one cycle.
REQ-021 RESP: SHALL hold rspK_valid=1 (K = owner) with stable rspK_result; the other rsp valid SHALL be 0.
REQ-022 RESP with rspK_ready=1 SHALL complete the handshake: next state IDLE, rspK_valid low next cycle, op_count +1.
REQ-023 rsp of the non-owner requester's ready SHALL be ignored.
REQ-024 Latency: request accepted at edge N -> rspK_valid high from cycle N+2; minimum issue interval 3 cycles (accept, calc, resp-handshake).
REQ-025 op_count SHALL wrap 0xFFFF -> 0x0000 silently.
REQ-026 rspK_result SHALL be driven from the result register only; value undefined-free (holds last result) when rspK_valid=0.
REQ-027 Requesters SHALL hold operands stable while valid and not ready; the block samples only on the ready cycle.
REQ-028 New request SHALL not be granted in the same cycle as a response handshake (IDLE only).

Reset
REQ-029 On rst=1 at an edge: state=IDLE, rr_ptr=0, op_count=0, result register=0, owner=0.
REQ-030 While rst=1: all reqN_ready=0, rspN_valid=0, busy=0.
REQ-031 Reset in CALC or RESP SHALL abort the operation; pending result is discarded and never presented.

Verification
REQ-032 req0 only, A=0x40000000 (2.0), B=0x40400000 (3.0), rsp0_ready=1 -> req0_ready at cycle 0, rsp0_valid at cycle 2 with 0x40C00000, op_count=1.
REQ-033 Both valid after reset, req0 1.5*1.5 (0x3FC00000 each), req1 -2.0*3.0 (0xC0000000, 0x40400000) -> req0 granted first, rsp0_result=0x40100000; then req1 granted, rsp1_result=0xC0C00000; rsp1_valid never high during owner-0 RESP.
REQ-034 Back-pressure: rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid and result held stable, busy=1, req1_ready stays 0, op_count unchanged until handshake.
REQ-035 Fairness: both requesters continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1.
REQ-036 Reset asserted in RESP with rsp0_ready=0 -> next cycle rsp0_valid=0, busy=0, op_count=0; no stale response after reset release.
REQ-037 Preload 0xFFFF completions (or force) then one more -> op_count=0x0000.
